hazard_scoreboard_unit: RTL and testbench
=========================================

# hazard_scoreboard_unit

Parametrised hazard unit for the in-order RV pipeline, generalising EX-stage operand forwarding to NUM_SRC source operands and adding ID-stage stall generation. Stalls cover load-use hazards and a register scoreboard that tracks long-latency (MDU) writes in flight. Sits alongside the ID/EX pipeline registers; drives the EX operand muxes and the ID/IF stall enables.

## Interface
- NUM_SRC, 2: source operands per instruction (2 or 3).
- REG_AW, 5: register address width; register count is 2**REG_AW.
- MAX_MDU, 4: maximum outstanding MDU writes (1..2**REG_AW-1).
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_id_rs  in  NUM_SRC×REG_AW  ID source register addresses
- i_id_rs_used  in  NUM_SRC  per-source "operand actually read"
- i_id_rd  in  REG_AW  ID destination; i_id_r_we  in  1  ID writes rd
- i_id_is_mdu  in  1  ID instruction is an MDU op
- i_ex_valid  in  1  EX holds a valid instruction
- i_ex_rs  in  NUM_SRC×REG_AW  EX source addresses
- i_ex_rd  in  REG_AW; i_ex_r_we  in  1; i_ex_is_load  in  1; i_ex_is_mdu  in  1
- i_mem_rd  in  REG_AW; i_mem_r_we  in  1
- i_wb_rd  in  REG_AW; i_wb_r_we  in  1
- i_mdu_done  in  1  MDU result written to regfile this cycle; i_mdu_rd  in  REG_AW  its destination
- o_fwd  out  NUM_SRC×add_op_fwd_t  per-source forward select
- o_stall_id  out  1  hold IF/ID, bubble into EX
- o_mdu_full  out  1  MAX_MDU writes outstanding
- o_mdu_cnt  out  $clog2(MAX_MDU+1)  outstanding MDU writes
- o_stall_load_cnt  out  32  load-use stall cycles
- o_stall_sb_cnt  out  32  scoreboard stall cycles

## Operation
- Forwarding (combinational), per source k: default FWD_ID_EX; FWD_EX_MEM if i_mem_r_we, i_mem_rd≠0, i_mem_rd==i_ex_rs[k]; else FWD_MEM_WB if i_wb_r_we, i_wb_rd≠0, i_wb_rd==i_ex_rs[k]. MEM has priority over WB. x0 never forwarded.
- Load-use stall: i_ex_valid & i_ex_is_load & i_ex_r_we & i_ex_rd≠0 & (some k with i_id_rs_used[k] & i_id_rs[k]==i_ex_rd).
- Scoreboard: one busy bit per register; bit 0 hardwired 0.
  - Set at edge: i_ex_valid & i_ex_is_mdu & i_ex_r_we & i_ex_rd≠0.
  - Clear at edge: i_mdu_done, bit i_mdu_rd.
  - Simultaneous set and clear of the same bit: set wins.
- Scoreboard stall, using registered busy only: RAW (used rs busy) | WAW (i_id_r_we & busy[i_id_rd]) | structural (i_id_is_mdu & o_mdu_full).
- o_stall_id = load-use | scoreboard stall.
- o_mdu_cnt: +1 on set, −1 on clear, unchanged when both occur. o_mdu_full = (o_mdu_cnt==MAX_MDU).
- Set with the count already at MAX_MDU or i_mdu_done on a non-busy register: illegal. The counter saturates at MAX_MDU and does not underflow below 0; assertion fires in simulation.

## Timing
- o_fwd, o_stall_id: combinational, same cycle as their inputs.
- Busy bit visible on the cycle after the set edge. The consumer in ID stalls through the i_mdu_done cycle and proceeds the next cycle, reading the written regfile; no MDU bypass.
- Load-use stall lasts exactly 1 cycle; afterwards the load is in MEM/WB and is forwarded.
- Reset (asynchronous, any time, including with writes outstanding): all busy bits 0, o_mdu_cnt 0, o_mdu_full 0, perf counters 0. Combinational outputs follow their inputs.

## Configuration
- HZD_PERF_CNT_EN defined: o_stall_load_cnt increments on each load-use stall cycle. o_stall_sb_cnt increments on each cycle with a scoreboard stall and no load-use stall. Both saturate at 2^32−1.
- HZD_PERF_CNT_EN undefined: both ports are constant 0 and no counter flops are generated.

## Structure
- rv_pkg holds: add_op_fwd_t (FWD_ID_EX, FWD_EX_MEM, FWD_MEM_WB), the shared register-address width constant, and hzd_cause_t (HZD_NONE, HZD_LOAD, HZD_RAW, HZD_WAW, HZD_STRUCT) for debug tracing.
- Sub-module reg_scoreboard holds the busy vector and the outstanding counter. It exposes busy lookup by address and o_mdu_cnt/o_mdu_full.

## Test plan
- EX rs1=5, MEM rd=5 we, WB rd=5 we -> o_fwd[0]=FWD_EX_MEM; MEM rd=0 with rs1=0 -> FWD_ID_EX.
- EX lw x7; ID add uses x7 -> o_stall_id=1 for 1 cycle, then o_fwd=FWD_EX_MEM... FWD_MEM_WB next cycle.
- Issue mul x9; ID uses x9 -> stall every cycle until i_mdu_done with rd=9; deasserted the cycle after.
- Issue 4 MDU ops (MAX_MDU=4) -> o_mdu_cnt=4, o_mdu_full=1; 5th MDU in ID stalls; done plus issue in the same cycle keeps the count at 4.
- Assert i_rst_n=0 mid-flight with 3 outstanding -> count 0 and busy cleared immediately; no stall afterwards.
- With HZD_PERF_CNT_EN, run 3 load-use stalls and 10 scoreboard stalls -> counters read 3 and 10; without the macro, both read 0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared pipeline types: forwarding selects, hazard causes and the
// register-address width used across the in-order RV core.
package rv_pkg;

   localparam int RV_REG_AW = 5;

   typedef enum logic [1:0] {
      FWD_ID_EX  = 2'd0,
      FWD_EX_MEM = 2'd1,
      FWD_MEM_WB = 2'd2
   } add_op_fwd_t;

   typedef enum logic [2:0] {
      HZD_NONE   = 3'd0,
      HZD_LOAD   = 3'd1,
      HZD_RAW    = 3'd2,
      HZD_WAW    = 3'd3,
      HZD_STRUCT = 3'd4
   } hzd_cause_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy bit per architectural register for MDU writes in flight, plus a
// saturating count of outstanding writes. Register x0 is never busy.
module reg_scoreboard
   import rv_pkg::*;
#(
   parameter int REG_AW     = RV_REG_AW,
   parameter int MAX_MDU    = 4,
   parameter int NUM_LOOKUP = 3,
   parameter int CNT_W      = $clog2(MAX_MDU + 1)
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst_n,
   input  logic                                  i_set,
   input  logic [REG_AW-1:0]                     i_set_rd,
   input  logic                                  i_clr,
   input  logic [REG_AW-1:0]                     i_clr_rd,
   input  logic [NUM_LOOKUP-1:0][REG_AW-1:0]     i_lookup_addr,
   output logic [NUM_LOOKUP-1:0]                 o_lookup_busy,
   output logic [CNT_W-1:0]                      o_mdu_cnt,
   output logic                                  o_mdu_full
);

   localparam int NUM_REG = 2 ** REG_AW;

   logic [NUM_REG-1:0] busy_q, busy_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // Set is applied after clear so a retire and re-issue of the same
   // register in one cycle leaves it busy.
   always_comb begin
      busy_d = busy_q;
      if (i_clr) busy_d[i_clr_rd] = 1'b0;
      if (i_set) busy_d[i_set_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (i_set && !i_clr) begin
         if (cnt_q != CNT_W'(MAX_MDU)) cnt_d = cnt_q + CNT_W'(1);
      end else if (i_clr && !i_set) begin
         if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      o_lookup_busy = '0;
      for (int k = 0; k < NUM_LOOKUP; k++) begin
         o_lookup_busy[k] = busy_q[i_lookup_addr[k]];
      end
   end

   assign o_mdu_cnt  = cnt_q;
   assign o_mdu_full = (cnt_q == CNT_W'(MAX_MDU));

`ifndef SYNTHESIS
   always @(posedge i_clk) begin
      if (i_rst_n) begin
         assert (!(i_set && !i_clr && o_mdu_full))
            else $error("mdu issue with %0d writes already outstanding", MAX_MDU);
         assert (!(i_clr && !busy_q[i_clr_rd]))
            else $error("mdu done on non-busy register x%0d", i_clr_rd);
      end
   end
`endif

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// EX operand forwarding and ID stall generation (load-use + MDU scoreboard).
// Optional stall performance counters are built when HZD_PERF_CNT_EN is defined.
module hazard_scoreboard_unit
   import rv_pkg::*;
#(
   parameter int NUM_SRC = 2,
   parameter int REG_AW  = RV_REG_AW,
   parameter int MAX_MDU = 4
) (
   input  logic                                i_clk,
   input  logic                                i_rst_n,
   input  logic [NUM_SRC-1:0][REG_AW-1:0]      i_id_rs,
   input  logic [NUM_SRC-1:0]                  i_id_rs_used,
   input  logic [REG_AW-1:0]                   i_id_rd,
   input  logic                                i_id_r_we,
   input  logic                                i_id_is_mdu,
   input  logic                                i_ex_valid,
   input  logic [NUM_SRC-1:0][REG_AW-1:0]      i_ex_rs,
   input  logic [REG_AW-1:0]                   i_ex_rd,
   input  logic                                i_ex_r_we,
   input  logic                                i_ex_is_load,
   input  logic                                i_ex_is_mdu,
   input  logic [REG_AW-1:0]                   i_mem_rd,
   input  logic                                i_mem_r_we,
   input  logic [REG_AW-1:0]                   i_wb_rd,
   input  logic                                i_wb_r_we,
   input  logic                                i_mdu_done,
   input  logic [REG_AW-1:0]                   i_mdu_rd,
   output add_op_fwd_t [NUM_SRC-1:0]           o_fwd,
   output logic                                o_stall_id,
   output logic                                o_mdu_full,
   output logic [$clog2(MAX_MDU+1)-1:0]        o_mdu_cnt,
   output logic [31:0]                         o_stall_load_cnt,
   output logic [31:0]                         o_stall_sb_cnt
);

   localparam int CNT_W = $clog2(MAX_MDU + 1);

   logic [NUM_SRC:0][REG_AW-1:0] lookup_addr;
   logic [NUM_SRC:0]             lookup_busy;
   logic                         mdu_set;
   logic                         load_use;
   logic                         raw_hit;
   logic                         waw_hit;
   logic                         struct_hit;
   hzd_cause_t                   cause;

   always_comb begin
      for (int k = 0; k < NUM_SRC; k++) begin
         o_fwd[k] = FWD_ID_EX;
         if (i_mem_r_we && (i_mem_rd != '0) && (i_mem_rd == i_ex_rs[k])) begin
            o_fwd[k] = FWD_EX_MEM;
         end else if (i_wb_r_we && (i_wb_rd != '0) && (i_wb_rd == i_ex_rs[k])) begin
            o_fwd[k] = FWD_MEM_WB;
         end
      end
   end

   always_comb begin
      load_use = 1'b0;
      if (i_ex_valid && i_ex_is_load && i_ex_r_we && (i_ex_rd != '0)) begin
         for (int k = 0; k < NUM_SRC; k++) begin
            if (i_id_rs_used[k] && (i_id_rs[k] == i_ex_rd)) load_use = 1'b1;
         end
      end
   end

   // Lookup ports 0..NUM_SRC-1 are the ID sources, the last one is ID rd.
   always_comb begin
      for (int k = 0; k < NUM_SRC; k++) lookup_addr[k] = i_id_rs[k];
      lookup_addr[NUM_SRC] = i_id_rd;
   end

   assign mdu_set = i_ex_valid & i_ex_is_mdu & i_ex_r_we & (i_ex_rd != '0);

   reg_scoreboard #(
      .REG_AW     (REG_AW),
      .MAX_MDU    (MAX_MDU),
      .NUM_LOOKUP (NUM_SRC + 1),
      .CNT_W      (CNT_W)
   ) u_reg_scoreboard (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_set         (mdu_set),
      .i_set_rd      (i_ex_rd),
      .i_clr         (i_mdu_done),
      .i_clr_rd      (i_mdu_rd),
      .i_lookup_addr (lookup_addr),
      .o_lookup_busy (lookup_busy),
      .o_mdu_cnt     (o_mdu_cnt),
      .o_mdu_full    (o_mdu_full)
   );

   assign raw_hit    = |(i_id_rs_used & lookup_busy[NUM_SRC-1:0]);
   assign waw_hit    = i_id_r_we & lookup_busy[NUM_SRC];
   assign struct_hit = i_id_is_mdu & o_mdu_full;

   // Load-use takes precedence so each stall cycle is attributed once.
   always_comb begin
      cause = HZD_NONE;
      if (load_use)        cause = HZD_LOAD;
      else if (raw_hit)    cause = HZD_RAW;
      else if (waw_hit)    cause = HZD_WAW;
      else if (struct_hit) cause = HZD_STRUCT;
   end

   assign o_stall_id = (cause != HZD_NONE);

`ifdef HZD_PERF_CNT_EN
   logic [31:0] stall_load_cnt_q;
   logic [31:0] stall_sb_cnt_q;
   logic        sb_only;

   assign sb_only = (cause != HZD_NONE) && (cause != HZD_LOAD);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stall_load_cnt_q <= '0;
         stall_sb_cnt_q   <= '0;
      end else begin
         if ((cause == HZD_LOAD) && (stall_load_cnt_q != '1)) begin
            stall_load_cnt_q <= stall_load_cnt_q + 32'd1;
         end
         if (sb_only && (stall_sb_cnt_q != '1)) begin
            stall_sb_cnt_q <= stall_sb_cnt_q + 32'd1;
         end
      end
   end

   assign o_stall_load_cnt = stall_load_cnt_q;
   assign o_stall_sb_cnt   = stall_sb_cnt_q;
`else
   assign o_stall_load_cnt = '0;
   assign o_stall_sb_cnt   = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit (NUM_SRC=2, REG_AW=5, MAX_MDU=4).
// Perf-counter expectations follow HZD_PERF_CNT_EN.
module tb_hazard_scoreboard_unit;
   import rv_pkg::*;

   logic                 i_clk;
   logic                 i_rst_n;
   logic [1:0][4:0]      i_id_rs;
   logic [1:0]           i_id_rs_used;
   logic [4:0]           i_id_rd;
   logic                 i_id_r_we;
   logic                 i_id_is_mdu;
   logic                 i_ex_valid;
   logic [1:0][4:0]      i_ex_rs;
   logic [4:0]           i_ex_rd;
   logic                 i_ex_r_we;
   logic                 i_ex_is_load;
   logic                 i_ex_is_mdu;
   logic [4:0]           i_mem_rd;
   logic                 i_mem_r_we;
   logic [4:0]           i_wb_rd;
   logic                 i_wb_r_we;
   logic                 i_mdu_done;
   logic [4:0]           i_mdu_rd;
   add_op_fwd_t [1:0]    o_fwd;
   logic                 o_stall_id;
   logic                 o_mdu_full;
   logic [2:0]           o_mdu_cnt;
   logic [31:0]          o_stall_load_cnt;
   logic [31:0]          o_stall_sb_cnt;

   int checks   = 0;
   int failures = 0;

   // {stall, cnt, full, fwd0, fwd1}
   logic [8:0] exp_q[$];
   logic [8:0] e;
   logic [8:0] obs;

   hazard_scoreboard_unit #(.NUM_SRC(2), .REG_AW(5), .MAX_MDU(4)) dut (
      .i_clk            (i_clk),
      .i_rst_n          (i_rst_n),
      .i_id_rs          (i_id_rs),
      .i_id_rs_used     (i_id_rs_used),
      .i_id_rd          (i_id_rd),
      .i_id_r_we        (i_id_r_we),
      .i_id_is_mdu      (i_id_is_mdu),
      .i_ex_valid       (i_ex_valid),
      .i_ex_rs          (i_ex_rs),
      .i_ex_rd          (i_ex_rd),
      .i_ex_r_we        (i_ex_r_we),
      .i_ex_is_load     (i_ex_is_load),
      .i_ex_is_mdu      (i_ex_is_mdu),
      .i_mem_rd         (i_mem_rd),
      .i_mem_r_we       (i_mem_r_we),
      .i_wb_rd          (i_wb_rd),
      .i_wb_r_we        (i_wb_r_we),
      .i_mdu_done       (i_mdu_done),
      .i_mdu_rd         (i_mdu_rd),
      .o_fwd            (o_fwd),
      .o_stall_id       (o_stall_id),
      .o_mdu_full       (o_mdu_full),
      .o_mdu_cnt        (o_mdu_cnt),
      .o_stall_load_cnt (o_stall_load_cnt),
      .o_stall_sb_cnt   (o_stall_sb_cnt)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish want finish");
      $fatal(1);
   end

   function automatic logic [8:0] mk(input logic s, input logic [2:0] c, input logic f,
                                     input add_op_fwd_t a, input add_op_fwd_t b);
      return {s, c, f, a, b};
   endfunction

   task automatic idle();
      i_id_rs = '0; i_id_rs_used = '0; i_id_rd = '0; i_id_r_we = 1'b0; i_id_is_mdu = 1'b0;
      i_ex_valid = 1'b0; i_ex_rs = '0; i_ex_rd = '0; i_ex_r_we = 1'b0;
      i_ex_is_load = 1'b0; i_ex_is_mdu = 1'b0;
      i_mem_rd = '0; i_mem_r_we = 1'b0; i_wb_rd = '0; i_wb_r_we = 1'b0;
      i_mdu_done = 1'b0; i_mdu_rd = '0;
   endtask

   task automatic next_cycle();
      @(posedge i_clk);
      #1;
      idle();
   endtask

   task automatic issue_mdu(input int rd);
      i_ex_valid = 1'b1; i_ex_is_mdu = 1'b1; i_ex_r_we = 1'b1; i_ex_rd = 5'(rd);
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      idle();
      #3;
      exp_q.push_back(mk(1'b0, 3'd0, 1'b0, FWD_ID_EX, FWD_ID_EX));
      e = exp_q.pop_front();
      obs = {o_stall_id, o_mdu_cnt, o_mdu_full, o_fwd[0], o_fwd[1]};
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL reset_state: got %b want %b", obs, e);
      end
      checks++;
      if (o_stall_load_cnt !== 32'd0 || o_stall_sb_cnt !== 32'd0) begin
         failures++;
         $display("FAIL reset_perf: got %0d/%0d want 0/0", o_stall_load_cnt, o_stall_sb_cnt);
      end
      @(negedge i_clk);
      i_rst_n = 1'b1;
   endtask

   task automatic test_forwarding();
      int          mem_rd [6] = '{5, 5, 6, 0, 6, 31};
      logic        mem_we [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      int          wb_rd  [6] = '{5, 5, 5, 0, 7, 31};
      logic        wb_we  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      int          rs0    [6] = '{5, 5, 5, 0, 5, 31};
      int          rs1    [6] = '{3, 5, 6, 0, 7, 31};
      add_op_fwd_t f0     [6] = '{FWD_EX_MEM, FWD_MEM_WB, FWD_MEM_WB, FWD_ID_EX, FWD_ID_EX, FWD_EX_MEM};
      add_op_fwd_t f1     [6] = '{FWD_ID_EX, FWD_MEM_WB, FWD_EX_MEM, FWD_ID_EX, FWD_ID_EX, FWD_EX_MEM};
      for (int i = 0; i < 6; i++) begin
         next_cycle();
         i_ex_valid = 1'b1;
         i_ex_rs[0] = 5'(rs0[i]); i_ex_rs[1] = 5'(rs1[i]);
         i_mem_rd = 5'(mem_rd[i]); i_mem_r_we = mem_we[i];
         i_wb_rd = 5'(wb_rd[i]); i_wb_r_we = wb_we[i];
         exp_q.push_back(mk(1'b0, 3'd0, 1'b0, f0[i], f1[i]));
         @(negedge i_clk);
         e = exp_q.pop_front();
         obs = {o_stall_id, o_mdu_cnt, o_mdu_full, o_fwd[0], o_fwd[1]};
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL fwd case %0d: got %b want %b", i, obs, e);
         end
      end
   endtask

   task automatic test_load_use();
      logic       v    [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic       ld   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      logic       we   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      int         rd   [8] = '{7, 7, 7, 0, 7, 7, 7, 7};
      int         rs0  [8] = '{7, 0, 7, 0, 7, 7, 7, 7};
      int         rs1  [8] = '{0, 7, 0, 0, 0, 0, 0, 7};
      logic [1:0] used [8] = '{2'b01, 2'b10, 2'b00, 2'b11, 2'b01, 2'b01, 2'b01, 2'b10};
      logic       st   [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         i_ex_valid = v[i]; i_ex_is_load = ld[i]; i_ex_r_we = we[i]; i_ex_rd = 5'(rd[i]);
         i_id_rs[0] = 5'(rs0[i]); i_id_rs[1] = 5'(rs1[i]); i_id_rs_used = used[i];
         exp_q.push_back(mk(st[i], 3'd0, 1'b0, FWD_ID_EX, FWD_ID_EX));
         @(negedge i_clk);
         e = exp_q.pop_front();
         obs = {o_stall_id, o_mdu_cnt, o_mdu_full, o_fwd[0], o_fwd[1]};
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL load_use case %0d: got %b want %b", i, obs, e);
         end
      end
      // lw x7 in EX with add x7 in ID, then the bubble, then add in EX
      for (int s = 0; s < 3; s++) begin
         next_cycle();
         case (s)
            0: begin
               i_ex_valid = 1'b1; i_ex_is_load = 1'b1; i_ex_r_we = 1'b1; i_ex_rd = 5'd7;
               i_id_rs[0] = 5'd7; i_id_rs_used = 2'b01;
               exp_q.push_back(mk(1'b1, 3'd0, 1'b0, FWD_ID_EX, FWD_ID_EX));
            end
            1: begin
               i_mem_rd = 5'd7; i_mem_r_we = 1'b1;
               i_id_rs[0] = 5'd7; i_id_rs_used = 2'b01;
               exp_q.push_back(mk(1'b0, 3'd0, 1'b0, FWD_ID_EX, FWD_ID_EX));
            end
            default: begin
               i_ex_valid = 1'b1; i_ex_rs[0] = 5'd7;
               i_wb_rd = 5'd7; i_wb_r_we = 1'b1;
               exp_q.push_back(mk(1'b0, 3'd0, 1'b0, FWD_MEM_WB, FWD_ID_EX));
            end
         endcase
         @(negedge i_clk);
         e = exp_q.pop_front();
         obs = {o_stall_id, o_mdu_cnt, o_mdu_full, o_fwd[0], o_fwd[1]};
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL load_use_seq step %0d: got %b want %b", s, obs, e);
         end
      end
   endtask

   task automatic test_scoreboard_raw();
      // 0 issue mul x9; 1-2 RAW; 3 WAW; 4 unused rs; 5 RAW; 6 done + RAW; 7 released
      logic st [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [2:0] c [8] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
      for (int s = 0; s < 8; s++) begin
         next_cycle();
         case (s)
            0: issue_mdu(9);
            3: begin i_id_rd = 5'd9; i_id_r_we = 1'b1; end
            4: begin i_id_rs[0] = 5'd9; i_id_rs_used = 2'b10; end
            6: begin
               i_id_rs[0] = 5'd9; i_id_rs_used = 2'b01;
               i_mdu_done = 1'b1; i_mdu_rd = 5'd9;
            end
            default: begin i_id_rs[0] = 5'd9; i_id_rs_used = 2'b01; end
         endcase
         exp_q.push_back(mk(st[s], c[s], 1'b0, FWD_ID_EX, FWD_ID_EX));
         @(negedge i_clk);
         e = exp_q.pop_front();
         obs = {o_stall_id, o_mdu_cnt, o_mdu_full, o_fwd[0], o_fwd[1]};
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL sb_raw step %0d: got %b want %b", s, obs, e);
         end
      end
   endtask

   task automatic test_mdu_full();
      logic       st [15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                              1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [2:0] c  [15] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4,
                              3'd4, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
      logic       f  [15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                              1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int s = 0; s < 15; s++) begin
         next_cycle();
         case (s)
            0, 1, 2, 3: issue_mdu(s + 1);
            4:  i_id_is_mdu = 1'b1;
            5:  begin i_mdu_done = 1'b1; i_mdu_rd = 5'd1; issue_mdu(5); end
            6:  begin i_id_rs[0] = 5'd1; i_id_rs_used = 2'b01; end
            7:  begin i_id_rs[0] = 5'd5; i_id_rs_used = 2'b01; end
            8:  begin i_mdu_done = 1'b1; i_mdu_rd = 5'd5; issue_mdu(5); end
            9:  begin i_id_rs[1] = 5'd5; i_id_rs_used = 2'b10; end
            10: begin i_mdu_done = 1'b1; i_mdu_rd = 5'd2; end
            11: begin i_mdu_done = 1'b1; i_mdu_rd = 5'd3; end
            12: begin i_mdu_done = 1'b1; i_mdu_rd = 5'd4; end
            13: begin i_mdu_done = 1'b1; i_mdu_rd = 5'd5; end
            default: begin i_id_rs[0] = 5'd5; i_id_rs_used = 2'b01; i_id_is_mdu = 1'b1; end
         endcase
         exp_q.push_back(mk(st[s], c[s], f[s], FWD_ID_EX, FWD_ID_EX));
         @(negedge i_clk);
         e = exp_q.pop_front();
         obs = {o_stall_id, o_mdu_cnt, o_mdu_full, o_fwd[0], o_fwd[1]};
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL mdu_full step %0d: got %b want %b", s, obs, e);
         end
      end
   endtask

   task automatic test_reset_midflight();
      for (int s = 0; s < 4; s++) begin
         next_cycle();
         if (s < 3) issue_mdu(10 + s);
         else begin i_id_rs[0] = 5'd10; i_id_rs_used = 2'b01; end
         exp_q.push_back(mk(s == 3, 3'(s), 1'b0, FWD_ID_EX, FWD_ID_EX));
         @(negedge i_clk);
         e = exp_q.pop_front();
         obs = {o_stall_id, o_mdu_cnt, o_mdu_full, o_fwd[0], o_fwd[1]};
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL midflight_setup step %0d: got %b want %b", s, obs, e);
         end
      end
      #2;
      i_rst_n = 1'b0;
      #1;
      exp_q.push_back(mk(1'b0, 3'd0, 1'b0, FWD_ID_EX, FWD_ID_EX));
      e = exp_q.pop_front();
      obs = {o_stall_id, o_mdu_cnt, o_mdu_full, o_fwd[0], o_fwd[1]};
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL midflight_reset: got %b want %b", obs, e);
      end
      checks++;
      if (o_stall_load_cnt !== 32'd0 || o_stall_sb_cnt !== 32'd0) begin
         failures++;
         $display("FAIL midflight_perf: got %0d/%0d want 0/0", o_stall_load_cnt, o_stall_sb_cnt);
      end
      #1;
      i_rst_n = 1'b1;
      next_cycle();
      i_id_rs[0] = 5'd11; i_id_rs[1] = 5'd12; i_id_rs_used = 2'b11;
      exp_q.push_back(mk(1'b0, 3'd0, 1'b0, FWD_ID_EX, FWD_ID_EX));
      @(negedge i_clk);
      e = exp_q.pop_front();
      obs = {o_stall_id, o_mdu_cnt, o_mdu_full, o_fwd[0], o_fwd[1]};
      checks++;
      if (obs !== e) begin
         failures++;
         $display("FAIL midflight_after: got %b want %b", obs, e);
      end
   endtask

   task automatic test_perf();
      logic [31:0] exp_l;
      logic [31:0] exp_s;
`ifdef HZD_PERF_CNT_EN
      exp_l = 32'd3;
      exp_s = 32'd10;
`else
      exp_l = 32'd0;
      exp_s = 32'd0;
`endif
      @(negedge i_clk);
      i_rst_n = 1'b0;
      idle();
      #2;
      i_rst_n = 1'b1;
      for (int s = 0; s < 3; s++) begin
         next_cycle();
         i_ex_valid = 1'b1; i_ex_is_load = 1'b1; i_ex_r_we = 1'b1; i_ex_rd = 5'd7;
         i_id_rs[1] = 5'd7; i_id_rs_used = 2'b10;
      end
      next_cycle();
      issue_mdu(9);
      for (int s = 0; s < 10; s++) begin
         next_cycle();
         i_id_rs[0] = 5'd9; i_id_rs_used = 2'b01;
      end
      next_cycle();
      i_mdu_done = 1'b1; i_mdu_rd = 5'd9;
      next_cycle();
      @(negedge i_clk);
      checks++;
      if (o_stall_load_cnt !== exp_l) begin
         failures++;
         $display("FAIL perf_load: got %0d want %0d", o_stall_load_cnt, exp_l);
      end
      checks++;
      if (o_stall_sb_cnt !== exp_s) begin
         failures++;
         $display("FAIL perf_sb: got %0d want %0d", o_stall_sb_cnt, exp_s);
      end
      checks++;
      if (o_mdu_cnt !== 3'd0 || o_stall_id !== 1'b0) begin
         failures++;
         $display("FAIL perf_drain: got cnt=%0d stall=%b want cnt=0 stall=0", o_mdu_cnt, o_stall_id);
      end
   endtask

   initial begin
      test_reset();
      test_forwarding();
      test_load_use();
      test_scoreboard_raw();
      test_mdu_full();
      test_reset_midflight();
      test_perf();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
